// File: rtl/dram_arb_pkg.sv
// ============================================================================
// Module : dram_arb_pkg
// Desc   : Shared types, default widths and round-robin pick for the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dram_arb_pkg;

  localparam int DEF_DATA_W  = 512;
  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_BURST_W = 7;
  localparam int MAX_CH_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MAX_CH_W-1:0]    ch;
    logic [DEF_BURST_W-1:0] burst;
  } rd_tag_t;

  // Returns {found, index}: first requester at or after start, wrapping at num_ch.
  function automatic logic [MAX_CH_W:0] rr_pick(input logic [7:0]          req,
                                                input logic [MAX_CH_W-1:0] start,
                                                input int unsigned         num_ch);
    logic [MAX_CH_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = (32'(start) + k) % num_ch;
      if (k < num_ch && !res[MAX_CH_W] && req[idx[2:0]])
        res = {1'b1, idx[MAX_CH_W-1:0]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_tag_fifo.sv
// ============================================================================
// Module : rd_tag_fifo
// Desc   : First-word fall-through FIFO of outstanding read tags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rd_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/dram_port_arbiter.sv
// ============================================================================
// Module : dram_port_arbiter
// Desc   : Round-robin N-channel Avalon-MM burst arbiter onto one EMIF port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_W   = DEF_BURST_W,
  parameter int MAX_OUTST = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_CH-1:0]         ch_read_i,
  input  logic [NUM_CH-1:0]         ch_write_i,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_address_i,
  input  logic [NUM_CH*BURST_W-1:0] ch_burstcount_i,
  input  logic [NUM_CH*DATA_W-1:0]  ch_writedata_i,
  output logic [NUM_CH-1:0]         ch_waitrequest_o,
  output logic [DATA_W-1:0]         ch_readdata_o,
  output logic [NUM_CH-1:0]         ch_readdatavalid_o,
  input  logic                      dram_waitrequest_i,
  input  logic [DATA_W-1:0]         dram_readdata_i,
  input  logic                      dram_readdatavalid_i,
  output logic [ADDR_W-1:0]         dram_address_o,
  output logic [BURST_W-1:0]        dram_burstcount_o,
  output logic [DATA_W-1:0]         dram_writedata_o,
  output logic                      dram_read_o,
  output logic                      dram_write_o,
  output logic                      busy_o,
  output logic                      ret_err_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TAG_W = CH_W + BURST_W;

  arb_state_t         state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_W-1:0] ret_cnt_q, ret_cnt_d;
  logic               ret_err_q, ret_err_d;

  logic [ADDR_W-1:0]  addr_a  [NUM_CH];
  logic [BURST_W-1:0] burst_a [NUM_CH];
  logic [DATA_W-1:0]  wdata_a [NUM_CH];

  logic [NUM_CH-1:0]  req;
  logic [MAX_CH_W:0]  pick;
  logic [BURST_W-1:0] sel_burst;
  logic [CH_W-1:0]    grant_next;
  logic               active;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TAG_W-1:0]   head_tag;
  logic [CH_W-1:0]    head_ch;
  logic [BURST_W-1:0] head_burst;
  logic               rdv_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_address_i[i*ADDR_W +: ADDR_W];
    assign burst_a[i] = ch_burstcount_i[i*BURST_W +: BURST_W];
    assign wdata_a[i] = ch_writedata_i[i*DATA_W +: DATA_W];
  end

  // A zero burstcount is promoted to a single beat everywhere it is used.
  assign sel_burst  = (burst_a[grant_q] == '0) ? BURST_W'(1) : burst_a[grant_q];
  assign grant_next = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
  assign active     = (state_q == RD) || (state_q == WR);

  assign req  = (ch_read_i | ch_write_i) & ~(fifo_full ? ch_read_i : '0);
  assign pick = rr_pick(8'(req), MAX_CH_W'(rr_ptr_q), NUM_CH);

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    rr_ptr_d          = rr_ptr_q;
    beat_cnt_d        = beat_cnt_q;
    fifo_push         = 1'b0;
    dram_read_o       = 1'b0;
    dram_write_o      = 1'b0;
    dram_address_o    = '0;
    dram_burstcount_o = '0;
    dram_writedata_o  = '0;
    case (state_q)
      IDLE: begin
        if (pick[MAX_CH_W]) begin
          grant_d    = pick[CH_W-1:0];
          beat_cnt_d = '0;
          state_d    = ch_read_i[pick[CH_W-1:0]] ? RD : WR;
        end
      end
      RD: begin
        dram_read_o       = 1'b1;
        dram_address_o    = addr_a[grant_q];
        dram_burstcount_o = sel_burst;
        if (!dram_waitrequest_i) begin
          fifo_push = 1'b1;
          rr_ptr_d  = grant_next;
          state_d   = IDLE;
        end
      end
      WR: begin
        dram_write_o      = 1'b1;
        dram_address_o    = addr_a[grant_q];
        dram_burstcount_o = sel_burst;
        dram_writedata_o  = wdata_a[grant_q];
        if (!dram_waitrequest_i) begin
          if (beat_cnt_q == sel_burst - BURST_W'(1)) begin
            beat_cnt_d = '0;
            rr_ptr_d   = grant_next;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign ch_waitrequest_o[i]   = !(grant_q == CH_W'(i) && active && !dram_waitrequest_i);
    assign ch_readdatavalid_o[i] = rdv_hit && (head_ch == CH_W'(i));
  end

  rd_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  ({grant_q, sel_burst}),
    .pop_i   (fifo_pop),
    .data_o  (head_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_ch    = head_tag[TAG_W-1 -: CH_W];
  assign head_burst = head_tag[BURST_W-1:0];
  assign rdv_hit    = dram_readdatavalid_i && !fifo_empty;
  assign fifo_pop   = rdv_hit && (ret_cnt_q == head_burst - BURST_W'(1));

  always_comb begin
    ret_cnt_d = ret_cnt_q;
    if (fifo_pop)     ret_cnt_d = '0;
    else if (rdv_hit) ret_cnt_d = ret_cnt_q + 1'b1;
    ret_err_d = ret_err_q | (dram_readdatavalid_i && fifo_empty);
  end

  assign ch_readdata_o = dram_readdata_i;
  assign busy_o        = (state_q != IDLE) || !fifo_empty;
  assign ret_err_o     = ret_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      ret_cnt_q  <= '0;
      ret_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      ret_err_q  <= ret_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
// ============================================================================
// Module : tb_dram_port_arbiter
// Desc   : Scoreboard bench with channel/bridge models for dram_port_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dram_port_arbiter;

  localparam int NUM_CH = 4, DATA_W = 512, ADDR_W = 28, BURST_W = 7, MAX_OUTST = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic [NUM_CH-1:0]         ch_read = '0, ch_write = '0;
  logic [NUM_CH*ADDR_W-1:0]  ch_address = '0;
  logic [NUM_CH*BURST_W-1:0] ch_burstcount = '0;
  logic [NUM_CH*DATA_W-1:0]  ch_writedata = '0;
  logic [NUM_CH-1:0]         ch_waitrequest, ch_readdatavalid;
  logic [DATA_W-1:0]         ch_readdata;
  logic                      dram_waitrequest = 1'b0, dram_readdatavalid = 1'b0;
  logic [DATA_W-1:0]         dram_readdata = '0;
  logic [ADDR_W-1:0]         dram_address;
  logic [BURST_W-1:0]        dram_burstcount;
  logic [DATA_W-1:0]         dram_writedata;
  logic                      dram_read, dram_write, busy, ret_err;

  dram_port_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                      .BURST_W(BURST_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .reset_i(reset),
    .ch_read_i(ch_read), .ch_write_i(ch_write), .ch_address_i(ch_address),
    .ch_burstcount_i(ch_burstcount), .ch_writedata_i(ch_writedata),
    .ch_waitrequest_o(ch_waitrequest), .ch_readdata_o(ch_readdata),
    .ch_readdatavalid_o(ch_readdatavalid),
    .dram_waitrequest_i(dram_waitrequest), .dram_readdata_i(dram_readdata),
    .dram_readdatavalid_i(dram_readdatavalid),
    .dram_address_o(dram_address), .dram_burstcount_o(dram_burstcount),
    .dram_writedata_o(dram_writedata), .dram_read_o(dram_read),
    .dram_write_o(dram_write), .busy_o(busy), .ret_err_o(ret_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit rd; logic [ADDR_W-1:0] addr; int burst;} cmd_t;
  typedef struct {int ch; logic [DATA_W-1:0] d;} ret_t;

  cmd_t              exp_cmd   [NUM_CH][$];
  logic [DATA_W-1:0] exp_wdata [NUM_CH][$];
  logic [DATA_W-1:0] wq        [NUM_CH][$];
  ret_t              exp_ret[$];
  int                model_beats[$];
  int                first_cyc[$], first_ch[$];

  bit act[NUM_CH], is_rd[NUM_CH];
  int beats_done[NUM_CH], quota[NUM_CH];
  int bridge_beats = 0, mode = 0, rate = 1, wreq_force = 0;
  bit hold_ret = 0, wait_rand = 0, force_spur = 0, spurious = 0, launch_en = 0;
  int cyc = 0, rd_cnt = 0, mon_wbeats = 0;
  int pass_cnt = 0, total_cnt = 0;

  task automatic check(string name, logic [DATA_W-1:0] act_v, logic [DATA_W-1:0] exp_v);
    total_cnt++;
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic launch(int i, bit rd, logic [ADDR_W-1:0] a, int b);
    int eff;
    cmd_t c;
    eff = (b == 0) ? 1 : b;
    act[i] = 1; is_rd[i] = rd; beats_done[i] = 0;
    ch_address[i*ADDR_W +: ADDR_W]     = a;
    ch_burstcount[i*BURST_W +: BURST_W] = BURST_W'(b);
    c.rd = rd; c.addr = a; c.burst = eff;
    exp_cmd[i].push_back(c);
    if (rd) ch_read[i] = 1'b1;
    else begin
      for (int k = 0; k < eff; k++) begin
        logic [DATA_W-1:0] d;
        d = rand_data();
        wq[i].push_back(d);
        exp_wdata[i].push_back(d);
      end
      ch_writedata[i*DATA_W +: DATA_W] = wq[i][0];
      ch_write[i] = 1'b1;
    end
  endtask

  // One clock of channel masters plus bridge: sample at negedge, drive after posedge.
  task automatic step();
    logic [NUM_CH-1:0] acc;
    bit bacc;
    int bb;
    logic [DATA_W-1:0] d;
    ret_t r;
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) acc[i] = (ch_read[i] | ch_write[i]) & ~ch_waitrequest[i];
    bacc = dram_read && !dram_waitrequest;
    bb   = int'(dram_burstcount);
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc[i] && act[i]) begin
        if (is_rd[i]) begin
          for (int k = 0; k < exp_burst(i); k++) model_beats.push_back(i);
          act[i] = 0; ch_read[i] = 1'b0; rd_cnt++;
        end else begin
          if (beats_done[i] == 0) begin first_cyc.push_back(cyc); first_ch.push_back(i); end
          beats_done[i]++;
          void'(wq[i].pop_front());
          if (wq[i].size() == 0) begin act[i] = 0; ch_write[i] = 1'b0; end
          else ch_writedata[i*DATA_W +: DATA_W] = wq[i][0];
        end
      end
    end
    cyc++;
    if (bacc) bridge_beats += bb;
    dram_readdatavalid = 1'b0; spurious = 0;
    if (force_spur) begin
      dram_readdatavalid = 1'b1; dram_readdata = rand_data(); spurious = 1; force_spur = 0;
    end else if (!hold_ret && bridge_beats > 0 && $urandom_range(0, 3) != 0) begin
      d = rand_data();
      dram_readdatavalid = 1'b1; dram_readdata = d; bridge_beats--;
      if (model_beats.size() == 0) spurious = 1;
      else begin r.ch = model_beats.pop_front(); r.d = d; exp_ret.push_back(r); end
    end
    if (wreq_force > 0) begin dram_waitrequest = 1'b1; wreq_force--; end
    else dram_waitrequest = wait_rand && ($urandom_range(0, 3) == 0);
    if (launch_en)
      for (int i = 0; i < NUM_CH; i++)
        if (!act[i] && quota[i] > 0 && $urandom_range(0, rate-1) == 0) begin
          quota[i]--;
          case (mode)
            1:       launch(i, 0, ADDR_W'(32'h1000 + i), 2);
            2:       launch(i, 1, ADDR_W'($urandom), 1);
            default: launch(i, $urandom_range(0, 1) == 1, ADDR_W'($urandom), $urandom_range(0, 5));
          endcase
        end
  endtask

  // Burst length of the read currently held by channel i (zero promoted to one).
  function automatic int exp_burst(int i);
    int b;
    b = int'(ch_burstcount[i*BURST_W +: BURST_W]);
    return (b == 0) ? 1 : b;
  endfunction

  function automatic bit pending();
    bit p;
    p = (bridge_beats > 0) || (model_beats.size() > 0);
    for (int i = 0; i < NUM_CH; i++) p |= act[i] || (launch_en && quota[i] > 0);
    return p;
  endfunction

  task automatic drain(string name);
    int n, left;
    n = 0;
    while (pending() && n < 20000) begin step(); n++; end
    repeat (3) step();
    check({name, "_drain_done"}, n < 20000, 1);
    left = exp_ret.size();
    for (int i = 0; i < NUM_CH; i++) left += exp_cmd[i].size() + exp_wdata[i].size();
    check({name, "_scoreboard_empty"}, left, 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_read = '0; ch_write = '0;
    dram_waitrequest = 1'b1; dram_readdatavalid = 1'b0; spurious = 0;
    bridge_beats = 0; wreq_force = 0;
    model_beats.delete(); exp_ret.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      act[i] = 0; exp_cmd[i].delete(); exp_wdata[i].delete(); wq[i].delete();
    end
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Monitor: compares every DUT output against the scoreboard at each negedge.
  bit   mon_rst_prev = 1'b1, model_err = 1'b0;
  int   mon_left[NUM_CH];
  cmd_t mon_cur[NUM_CH];

  initial begin : monitor
    forever begin
      int nlow, chsel;
      bit dacc;
      cmd_t c;
      ret_t r;
      @(negedge clk);
      if (mon_rst_prev) begin
        model_err = 0;
        for (int i = 0; i < NUM_CH; i++) mon_left[i] = 0;
        check("rst_ch_waitrequest", ch_waitrequest, {NUM_CH{1'b1}});
        check("rst_dram_strobes", {dram_read, dram_write}, 0);
        check("rst_dram_addr_burst", {dram_address, dram_burstcount}, 0);
        check("rst_dram_wdata", dram_writedata, 0);
        check("rst_ch_rdv", ch_readdatavalid, 0);
        check("rst_busy_err", {busy, ret_err}, 0);
      end else begin
        nlow = 0; chsel = 0;
        for (int i = 0; i < NUM_CH; i++) if (!ch_waitrequest[i]) begin nlow++; chsel = i; end
        dacc = (dram_read || dram_write) && !dram_waitrequest;
        check("accept_onehot", nlow, dacc);
        if (dacc && nlow == 1) begin
          if (dram_read) begin
            check("rd_cmd_expected", exp_cmd[chsel].size() != 0, 1);
            if (exp_cmd[chsel].size() != 0) begin
              c = exp_cmd[chsel].pop_front();
              check("rd_is_read", c.rd, 1);
              check("rd_addr", dram_address, c.addr);
              check("rd_burst", dram_burstcount, c.burst);
            end
          end else begin
            if (mon_left[chsel] == 0) begin
              check("wr_cmd_expected", exp_cmd[chsel].size() != 0, 1);
              if (exp_cmd[chsel].size() != 0) begin
                mon_cur[chsel]  = exp_cmd[chsel].pop_front();
                mon_left[chsel] = mon_cur[chsel].burst;
                check("wr_is_write", mon_cur[chsel].rd, 0);
              end
            end
            check("wr_addr", dram_address, mon_cur[chsel].addr);
            check("wr_burst", dram_burstcount, mon_cur[chsel].burst);
            check("wr_beat_expected", exp_wdata[chsel].size() != 0, 1);
            if (exp_wdata[chsel].size() != 0) check("wr_data", dram_writedata, exp_wdata[chsel].pop_front());
            if (mon_left[chsel] > 0) mon_left[chsel]--;
            mon_wbeats++;
          end
        end
        if (dram_readdatavalid) begin
          if (spurious) check("spurious_rdv_dropped", ch_readdatavalid, 0);
          else begin
            check("ret_expected", exp_ret.size() != 0, 1);
            if (exp_ret.size() != 0) begin
              r = exp_ret.pop_front();
              check("ret_onehot", ch_readdatavalid, 1 << r.ch);
              check("ret_data", ch_readdata, r.d);
            end
          end
        end else check("rdv_quiet", ch_readdatavalid, 0);
        check("ret_err", ret_err, model_err);
        if (dram_readdatavalid && spurious) model_err = 1;
      end
      mon_rst_prev = reset;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int c0, r0, w0, n;
    for (int i = 0; i < NUM_CH; i++) begin act[i] = 0; quota[i] = 0; beats_done[i] = 0; end
    repeat (4) step();

    // Contention: every channel writes burst 2 back to back from reset release.
    reset = 1'b0; mode = 1; rate = 1;
    first_cyc.delete(); first_ch.delete();
    for (int i = 0; i < NUM_CH; i++) begin launch(i, 0, ADDR_W'(32'h1000 + i), 2); quota[i] = 1; end
    c0 = cyc; launch_en = 1;
    drain("contention");
    launch_en = 0;
    check("contention_bursts", first_ch.size() >= 5, 1);
    if (first_ch.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        check("contention_grant_ch", first_ch[k], k % NUM_CH);
        check("contention_grant_cycle", first_cyc[k] - c0, 1 + 3*k);
      end

    // Single read from channel 2.
    launch(2, 1, ADDR_W'(32'h100), 4);
    drain("single_read");

    // Randomised mix of reads/writes with bridge stalls.
    mode = 0; rate = 3; wait_rand = 1;
    for (int i = 0; i < NUM_CH; i++) quota[i] = 50;
    launch_en = 1;
    drain("random");
    launch_en = 0; wait_rand = 0;

    // Backpressure mid write burst.
    w0 = mon_wbeats;
    launch(2, 0, ADDR_W'(32'h2000), 8);
    n = 0;
    while (beats_done[2] < 3 && n < 100) begin step(); n++; end
    wreq_force = 5;
    drain("backpressure");
    check("backpressure_beats", mon_wbeats - w0, 8);

    // Outstanding limit: nine single-beat reads with returns held back.
    hold_ret = 1; mode = 2; rate = 1; r0 = rd_cnt;
    quota[0] = 3; quota[1] = 2; quota[2] = 2; quota[3] = 2;
    launch_en = 1;
    repeat (30) step();
    check("outstanding_capped", rd_cnt - r0, MAX_OUTST);
    hold_ret = 0;
    drain("outstanding");
    launch_en = 0;
    check("outstanding_all_issued", rd_cnt - r0, 9);

    // ch3 burst 2 then ch0 burst 3 returned in issue order.
    launch(3, 1, ADDR_W'(32'h300), 2);
    n = 0;
    while (act[3] && n < 100) begin step(); n++; end
    launch(0, 1, ADDR_W'(32'h400), 3);
    drain("order");

    // Return with nothing outstanding, then reset in the middle of a write.
    force_spur = 1;
    repeat (4) step();
    check("ret_err_sticky", ret_err, 1);
    launch(1, 0, ADDR_W'(32'h3000), 8);
    n = 0;
    while (beats_done[1] < 3 && n < 100) begin step(); n++; end
    do_reset();
    repeat (3) step();
    check("post_reset_err_clear", ret_err, 0);
    drain("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
